// File: rtl/operand_read_pkg.sv
// operand_read_pkg: shared constants and index types for the Pillar pipeline stages.
//   XLEN     - register / operand width
//   NREGS    - number of architectural registers
//   REG_AW   - register index width (fixed at 5)
//   REG_ZERO - index of the hard-wired zero register
package operand_read_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;

endpackage

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: one busy bit per architectural register.
//   clk, reset (async, active-low)
//   set_valid_i / set_idx_i   - accepted instruction claims a destination
//   clr_valid_i / clr_idx_i   - write-back releases a destination
//   rs1_i, rs2_i              - source indices to query
//   rd_we_i, rd_i             - destination to query for a WAW hazard
//   rs1_blocked_o, rs2_blocked_o, waw_o - combinational hazard results
// Optional feature: OPERAND_READ_BYPASS_EN lets a same-cycle write-back unblock a source.
module operand_scoreboard
    import operand_read_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_valid_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_valid_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rd_we_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              rs1_blocked_o,
    output logic              rs2_blocked_o,
    output logic              waw_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             byp1, byp2;

    // Set is applied after clear so it wins on a collision; bit 0 is pinned low.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i && clr_idx_i != REG_ZERO) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_valid_i && set_idx_i != REG_ZERO) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef OPERAND_READ_BYPASS_EN
    assign byp1 = clr_valid_i && (clr_idx_i == rs1_i);
    assign byp2 = clr_valid_i && (clr_idx_i == rs2_i);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_blocked_o = (rs1_i != REG_ZERO) && busy_q[rs1_i] && !byp1;
    assign rs2_blocked_o = (rs2_i != REG_ZERO) && busy_q[rs2_i] && !byp2;
    // The write-back clear is deliberately not bypassed here.
    assign waw_o         = rd_we_i && (rd_i != REG_ZERO) && busy_q[rd_i];

endmodule

// File: rtl/operand_read.sv
// operand_read: register-file read stage of the Pillar pipeline.
//   clk, reset (async, active-low)
//   wb_*   - write-back port, one register write per cycle
//   iss_*  - issue handshake from decode (valid/ready), sources, destination, PC
//   op_*   - registered operand bundle to execute (valid/ready)
// Optional feature: OPERAND_READ_BYPASS_EN (see operand_scoreboard) forwards a same-cycle
// write-back to a source that would otherwise be blocked.
module operand_read
    import operand_read_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              iss_valid_i,
    output logic              iss_ready_o,
    input  logic [REG_AW-1:0] iss_rs1_i,
    input  logic [REG_AW-1:0] iss_rs2_i,
    input  logic [REG_AW-1:0] iss_rd_i,
    input  logic              iss_rd_we_i,
    input  logic [31:0]       iss_pc_i,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [XLEN-1:0]   op_rs1_data_o,
    output logic [XLEN-1:0]   op_rs2_data_o,
    output logic [REG_AW-1:0] op_rd_o,
    output logic [31:0]       op_pc_o
);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic              wb_en;
    logic              rs1_blocked, rs2_blocked, waw;
    logic              accept;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    logic              op_valid_q;
    logic [XLEN-1:0]   op_rs1_q, op_rs2_q;
    logic [REG_AW-1:0] op_rd_q;
    logic [31:0]       op_pc_q;

    assign wb_en = wb_valid_i && (wb_rd_i != REG_ZERO);

    operand_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .set_valid_i   (accept && iss_rd_we_i),
        .set_idx_i     (iss_rd_i),
        .clr_valid_i   (wb_valid_i),
        .clr_idx_i     (wb_rd_i),
        .rs1_i         (iss_rs1_i),
        .rs2_i         (iss_rs2_i),
        .rd_we_i       (iss_rd_we_i),
        .rd_i          (iss_rd_i),
        .rs1_blocked_o (rs1_blocked),
        .rs2_blocked_o (rs2_blocked),
        .waw_o         (waw)
    );

    assign iss_ready_o = !rs1_blocked && !rs2_blocked && !waw && (!op_valid_q || op_ready_i);
    assign accept      = iss_valid_i && iss_ready_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // Operand read with same-cycle write-back forwarding; x0 is forced to zero.
    always_comb begin
        rs1_val = regs_q[iss_rs1_i];
        rs2_val = regs_q[iss_rs2_i];
        if (wb_en && wb_rd_i == iss_rs1_i) begin
            rs1_val = wb_data_i;
        end
        if (wb_en && wb_rd_i == iss_rs2_i) begin
            rs2_val = wb_data_i;
        end
        if (iss_rs1_i == REG_ZERO) begin
            rs1_val = '0;
        end
        if (iss_rs2_i == REG_ZERO) begin
            rs2_val = '0;
        end
    end

    // EMPTY/FULL output register: data only moves on accept, so it holds while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_valid_q <= 1'b0;
            op_rs1_q   <= '0;
            op_rs2_q   <= '0;
            op_rd_q    <= '0;
            op_pc_q    <= '0;
        end else if (accept) begin
            op_valid_q <= 1'b1;
            op_rs1_q   <= rs1_val;
            op_rs2_q   <= rs2_val;
            op_rd_q    <= iss_rd_i;
            op_pc_q    <= iss_pc_i;
        end else if (op_ready_i) begin
            op_valid_q <= 1'b0;
        end
    end

    assign op_valid_o    = op_valid_q;
    assign op_rs1_data_o = op_rs1_q;
    assign op_rs2_data_o = op_rs2_q;
    assign op_rd_o       = op_rd_q;
    assign op_pc_o       = op_pc_q;

endmodule

// File: tb/tb_operand_read.sv
module tb_operand_read;

`ifdef OPERAND_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_rd_we;
    logic [31:0] iss_pc;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rs1, op_rs2;
    logic [4:0]  op_rd;
    logic [31:0] op_pc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_rs1, m_rs2, m_pc;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    operand_read dut (
        .clk           (clk),
        .reset         (reset),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .iss_valid_i   (iss_valid),
        .iss_ready_o   (iss_ready),
        .iss_rs1_i     (iss_rs1),
        .iss_rs2_i     (iss_rs2),
        .iss_rd_i      (iss_rd),
        .iss_rd_we_i   (iss_rd_we),
        .iss_pc_i      (iss_pc),
        .op_valid_o    (op_valid),
        .op_ready_i    (op_ready),
        .op_rs1_data_o (op_rs1),
        .op_rs2_data_o (op_rs2),
        .op_rd_o       (op_rd),
        .op_pc_o       (op_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_we = 0; iss_pc = 0;
        op_ready = 1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [31:0] pc);
        iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_we = we; iss_pc = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 0;
        @(negedge clk);
        reset = 1;
    endtask

    function automatic bit m_blocked(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(BYP && wb_valid && wb_rd == r);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_valid && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    initial begin
        reset = 0;
        idle_inputs();
        #12;
        check_eq("rst_valid", op_valid, 0);
        check_eq("rst_rs1", op_rs1, 0);
        check_eq("rst_pc", op_pc, 0);
        @(negedge clk);
        reset = 1;

        // x5 = 0x1234, then read rs1=5, rs2=0
        @(negedge clk); wb_valid = 1; wb_rd = 5; wb_data = 32'h1234;
        @(negedge clk); wb_valid = 0; issue(5, 0, 1, 0, 32'h100);
        #1 check_eq("t1_ready", iss_ready, 1);
        @(posedge clk); #1;
        check_eq("t1_valid", op_valid, 1);
        check_eq("t1_rs1", op_rs1, 32'h1234);
        check_eq("t1_rs2", op_rs2, 0);
        check_eq("t1_pc", op_pc, 32'h100);

        // x0 write ignored; rd=0 never sets busy
        @(negedge clk); iss_valid = 0; wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF;
        @(negedge clk); wb_valid = 0; issue(0, 0, 0, 1, 32'h104);
        #1 check_eq("x0_ready", iss_ready, 1);
        @(posedge clk); #1 check_eq("x0_rs1", op_rs1, 0);
        @(negedge clk); issue(0, 0, 0, 1, 32'h108);
        #1 check_eq("x0_no_busy", iss_ready, 1);

        // RAW on x7
        @(negedge clk); issue(0, 0, 7, 1, 32'h10C);
        #1 check_eq("raw_set_ready", iss_ready, 1);
        @(negedge clk); issue(7, 0, 2, 0, 32'h110);
        #1 check_eq("raw_stall", iss_ready, 0);
        @(negedge clk); wb_valid = 1; wb_rd = 7; wb_data = 32'hA5;
        #1 check_eq("raw_wb_cycle", iss_ready, BYP);
        if (!BYP) begin
            @(negedge clk); wb_valid = 0;
            #1 check_eq("raw_after_wb", iss_ready, 1);
        end
        @(posedge clk); #1;
        check_eq("raw_rs1", op_rs1, 32'hA5);
        check_eq("raw_pc", op_pc, 32'h110);

        // Same-cycle set and clear of x3: set wins
        @(negedge clk); wb_valid = 1; wb_rd = 3; wb_data = 32'h77; issue(0, 0, 3, 1, 32'h114);
        #1 check_eq("sc_ready", iss_ready, 1);
        @(negedge clk); wb_valid = 0; issue(3, 0, 4, 0, 32'h118);
        #1 check_eq("sc_busy", iss_ready, 0);
        @(negedge clk); iss_valid = 0; wb_valid = 1; wb_rd = 3; wb_data = 32'h88;
        @(negedge clk); wb_valid = 0;

        // Hold for 3 cycles under back-pressure
        @(negedge clk); op_ready = 0; issue(5, 3, 10, 0, 32'h200);
        @(posedge clk); #1;
        check_eq("hold_valid", op_valid, 1);
        check_eq("hold_rs2", op_rs2, 32'h88);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); issue(0, 0, 11, 0, 32'h300);
            #1 check_eq("hold_ready", iss_ready, 0);
            @(posedge clk); #1;
            check_eq("hold_pc", op_pc, 32'h200);
            check_eq("hold_rs1", op_rs1, 32'h1234);
        end
        @(negedge clk); op_ready = 1;
        #1 check_eq("release_ready", iss_ready, 1);
        @(posedge clk); #1 check_eq("release_pc", op_pc, 32'h300);

        // Reset in the middle of a transfer with busy[9] set
        @(negedge clk); iss_valid = 0; wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
        @(negedge clk); wb_valid = 0; op_ready = 0; issue(0, 0, 9, 1, 32'h400);
        @(negedge clk); iss_valid = 0;
        #2 reset = 0;
        #1;
        check_eq("arst_valid", op_valid, 0);
        check_eq("arst_pc", op_pc, 0);
        @(negedge clk); reset = 1; op_ready = 1; issue(9, 9, 9, 1, 32'h500);
        #1 check_eq("arst_busy", iss_ready, 1);
        @(posedge clk); #1;
        check_eq("arst_x9", op_rs1, 0);

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_pc = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit b1, b2, waw, rdy, acc;
            logic [31:0] v1, v2;
            @(negedge clk);
            check_eq("rnd_valid", op_valid, m_valid);
            check_eq("rnd_rs1", op_rs1, m_rs1);
            check_eq("rnd_rs2", op_rs2, m_rs2);
            check_eq("rnd_rd", op_rd, m_rd);
            check_eq("rnd_pc", op_pc, m_pc);
            wb_valid  = ($urandom_range(0, 99) < 45);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            iss_valid = ($urandom_range(0, 99) < 80);
            iss_rs1   = 5'($urandom_range(0, 7));
            iss_rs2   = 5'($urandom_range(0, 7));
            iss_rd    = 5'($urandom_range(0, 7));
            iss_rd_we = $urandom_range(0, 1);
            iss_pc    = $urandom;
            op_ready  = ($urandom_range(0, 99) < 70);
            #1;
            b1  = m_blocked(iss_rs1);
            b2  = m_blocked(iss_rs2);
            waw = iss_rd_we && iss_rd != 0 && m_busy[iss_rd];
            rdy = !b1 && !b2 && !waw && (!m_valid || op_ready);
            check_eq("rnd_ready", iss_ready, rdy);
            acc = iss_valid && rdy;
            v1  = m_read(iss_rs1);
            v2  = m_read(iss_rs2);
            if (acc) begin
                m_valid = 1; m_rs1 = v1; m_rs2 = v2; m_rd = iss_rd; m_pc = iss_pc;
            end else if (op_ready) begin
                m_valid = 0;
            end
            if (wb_valid && wb_rd != 0) begin
                m_regs[wb_rd] = wb_data;
                m_busy[wb_rd] = 0;
            end
            if (acc && iss_rd_we && iss_rd != 0) m_busy[iss_rd] = 1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_read.md
# operand_read

Register-file read stage for the Pillar pipeline and the consumer end of the write-back interface. It holds the 32 x 32-bit architectural register file, accepts one write per cycle from write-back, and serves two operand reads per issued instruction. A busy-bit scoreboard stalls decode until every source operand has been written back. Sits between decode (issue side) and execute (operand side).

## Interface
- XLEN, 32, data width of registers and operands
- NREGS, 32, number of architectural registers; the address width is fixed at 5

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wb_valid_i  in  1  write-back write strobe for this cycle
- wb_rd_i  in  5  write-back destination register
- wb_data_i  in  XLEN  write-back data
- iss_valid_i  in  1  decode presents an instruction
- iss_ready_o  out  1  stage accepts the instruction this cycle
- iss_rs1_i, iss_rs2_i  in  5 each  source register indices
- iss_rd_i  in  5  destination register index
- iss_rd_we_i  in  1  instruction will write iss_rd_i
- iss_pc_i  in  32  PC, carried through to the operand side
- op_valid_o  out  1  operand bundle valid
- op_ready_i  in  1  execute accepts the bundle
- op_rs1_data_o, op_rs2_data_o  out  XLEN each  operand values
- op_rd_o  out  5  destination register, carried through
- op_pc_o  out  32  PC, carried through

## Operation
- Register file: x0 reads as 0. A write-back to x0 is ignored.
- Write-back: when wb_valid_i is 1 and wb_rd_i is not 0, regs[wb_rd_i] is written with wb_data_i at the clock edge, and busy[wb_rd_i] is cleared. A write to a register whose busy bit is already clear still updates the register; the clear has no effect.
- Scoreboard: there is one busy bit per register, and busy[0] is always 0. An accepted instruction with iss_rd_we_i=1 and iss_rd_i not 0 sets busy[iss_rd_i].
- Busy-bit update: next busy = (busy & ~clear) | set. If set and clear target the same register in the same cycle, set wins.
- A source register is blocked when its index is not 0 and its busy bit is 1. A bypass exception applies only when the feature in Configuration is compiled in.
- WAW hazard: the stage stalls when iss_rd_we_i=1, iss_rd_i is not 0, and busy[iss_rd_i] is 1. The write-back clear is not bypassed for this check.
- iss_ready_o = no blocked source, no WAW hazard, and (op_valid_o is 0 or op_ready_i is 1). iss_ready_o is combinational and does not depend on iss_valid_i.
- Accept condition: iss_valid_i and iss_ready_o. On accept, the output register loads the operands, rd and pc. A write to the source register in the same cycle is forwarded into the loaded operand.
- Hold: while op_valid_o is 1 and op_ready_i is 0, all op_* outputs stay stable.
- Drain: if op_ready_i is 1 and there is no accept, op_valid_o goes to 0.
- The stage has only two states, EMPTY (op_valid_o=0) and FULL (op_valid_o=1). A bubble between them is not required.

## Timing
- Reset (asserted low) clears all registers and all busy bits. It also sets op_valid_o=0 and every op_* data output to 0. Reset takes effect immediately, even in the middle of a transfer.
- Latency: an instruction accepted at edge N is presented on op_* after edge N, with op_valid_o=1.
- Throughput: one instruction per cycle while execute accepts and there are no hazards.
- Register update: a write-back at edge N is visible to a plain read from edge N onward.
- Without bypass: a dependent instruction that is stalled on a busy source becomes ready in the cycle after the clearing write-back.
- With bypass: a dependent instruction becomes ready in the same cycle as the clearing write-back.

## Configuration
- OPERAND_READ_BYPASS_EN defined: a blocked source is unblocked when wb_valid_i is 1 and wb_rd_i equals that source. iss_ready_o may then rise in that cycle, and the operand captures wb_data_i.
- OPERAND_READ_BYPASS_EN undefined: busy[rs] alone decides readiness. This adds one stall cycle per RAW hazard and removes the wb-to-ready combinational path.

## Structure
- XLEN, NREGS, the register index width of 5, and REG_ZERO=0 go in the shared opcode/constants include used by the pipeline stages.
- The scoreboard is a natural sub-module, operand_scoreboard. It has the set/clear ports and two combinational source-blocked queries plus one WAW query.
- The register array, the forwarding muxes and the output register stay in operand_read.

## Test plan
- Reset, then write x5=0x1234 via write-back, then issue rs1=5, rs2=0. Required: op_rs1_data_o=0x1234, op_rs2_data_o=0, and op_valid_o=1 one edge after the accept.
- Issue rd=7 with we=1, then issue rs1=7. Required: iss_ready_o=0 until write-back of x7=0xA5. Without the bypass feature, ready rises the cycle after that write and the operand is 0xA5. With the feature, ready rises in the write cycle and the operand is 0xA5.
- Hold op_ready_i=0 with op_valid_o=1 for 3 cycles. Required: op_* outputs are unchanged and iss_ready_o=0. Raising op_ready_i with iss_valid_i=1 accepts the instruction in that cycle.
- Issue rd=3 with we=1 in the same cycle as write-back of x3. Required: busy[3] stays 1, so a following rs1=3 instruction stalls.
- Write-back of x0=0xFFFF, then issue rs1=0. Required: operand is 0 with no stall. Issuing rd=0 with we=1 never sets busy.
- Assert reset while op_valid_o=1 and busy[9]=1. Required: op_valid_o=0, all busy bits clear, and x9 reads 0 after reset is released.
